// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: one partial-product step per clock,
// unsigned or two's-complement operands, 2*WIDTH-bit registered result.
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 sign_mode,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   z,
  output logic                 zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic                 neg;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;

  // Magnitude of the most-negative value is 2^(WIDTH-1), which still fits
  // in WIDTH unsigned bits, so the shift-add core stays purely unsigned.
  always_comb begin
    a_mag = (sign_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag = (sign_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  assign zero = (z == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      z      <= '0;
      neg    <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg    <= sign_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (clear) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mplier <= mplier >> 1;
            mcand  <= mcand << 1;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) state <= DONE;
          end
        end
        DONE: begin
          if (!clear) begin
            z    <= neg ? (~acc + 1'b1) : acc;
            done <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: 8-bit and 32-bit instances, directed vector table,
// randomized ops against an arithmetic model, and multi-cycle corner sequences.
module tb_mult_seq;

  logic clk, reset_n;
  logic start8, sm8, clear8, busy8, done8, zero8;
  logic [7:0]  a8, b8;
  logic [15:0] z8;
  logic start32, sm32, clear32, busy32, done32, zero32;
  logic [31:0] a32, b32;
  logic [63:0] z32;

  int checks = 0;
  int errors = 0;

  mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .sign_mode(sm8), .clear(clear8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .z(z8), .zero(zero8));

  mult_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .start(start32), .sign_mode(sm32), .clear(clear32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .z(z32), .zero(zero32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          w32;
    bit          sm;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference product: interpret operands per mode, multiply, keep 2*w bits.
  function automatic logic [63:0] ref_mul(input bit w32, input bit sm,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, p;
    if (w32) begin
      sa = sm ? {{32{a[31]}}, a} : {32'b0, a};
      sb = sm ? {{32{b[31]}}, b} : {32'b0, b};
    end else begin
      sa = sm ? {{56{a[7]}}, a[7:0]} : {56'b0, a[7:0]};
      sb = sm ? {{56{b[7]}}, b[7:0]} : {56'b0, b[7:0]};
    end
    p = sa * sb;
    return w32 ? p : (p & 64'hFFFF);
  endfunction

  function automatic logic [63:0] cur_z(input bit w32);
    return w32 ? z32 : {48'b0, z8};
  endfunction

  function automatic logic cur_done(input bit w32);
    return w32 ? done32 : done8;
  endfunction

  // Launch one op, wait (bounded) for done; lat counts edges after the start edge.
  task automatic run_op(input bit w32, input bit sm, input logic [31:0] a,
                        input logic [31:0] b, output logic [63:0] zr, output int lat);
    @(negedge clk);
    if (w32) begin a32 = a; b32 = b; sm32 = sm; start32 = 1'b1; end
    else     begin a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; start8 = 1'b1; end
    @(negedge clk);
    start32 = 1'b0; start8 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (cur_done(w32)) begin lat = k; break; end
    end
    zr = cur_z(w32);
  endtask

  task automatic do_check_op(input string nm, input bit w32, input bit sm,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp);
    logic [63:0] zr;
    int lat;
    run_op(w32, sm, a, b, zr, lat);
    chk({nm, "_z"}, zr, exp);
    chk({nm, "_lat"}, 64'(lat), w32 ? 64'd33 : 64'd9);
    chk({nm, "_zero"}, 64'(w32 ? zero32 : zero8), 64'(exp == 64'd0));
    @(negedge clk);
    chk({nm, "_done_1cyc"}, 64'(cur_done(w32)), 64'd0);
  endtask

  initial begin
    logic [63:0] zr;
    int lat, nd, last;
    logic [63:0] expq[$];

    vecs[0] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[1] = '{1'b0, 1'b1, 32'h80, 32'h80, 64'h4000};
    vecs[2] = '{1'b0, 1'b1, 32'h80, 32'h01, 64'hFF80};
    vecs[3] = '{1'b0, 1'b1, 32'hFD, 32'h07, 64'hFFEB};
    vecs[4] = '{1'b0, 1'b0, 32'hFF, 32'hFF, 64'hFE01};
    vecs[5] = '{1'b1, 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000};
    vecs[6] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000001, 64'hFFFFFFFFFFFFFFFF};

    start8 = 0; sm8 = 0; clear8 = 0; a8 = 0; b8 = 0;
    start32 = 0; sm32 = 0; clear32 = 0; a32 = 0; b32 = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_z8", 64'(z8), 64'd0);
    chk("rst_z32", z32, 64'd0);
    chk("rst_busy", 64'({busy8, busy32}), 64'd0);
    chk("rst_done", 64'({done8, done32}), 64'd0);
    chk("rst_zero", 64'({zero8, zero32}), 64'd3);
    reset_n = 1'b1;

    // Directed table
    foreach (vecs[i])
      do_check_op($sformatf("vec%0d", i), vecs[i].w32, vecs[i].sm, vecs[i].a,
                  vecs[i].b, vecs[i].exp);

    // Randomized ops against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      bit w, s;
      logic [31:0] ra, rb;
      w = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
      ra = $urandom; rb = $urandom;
      if (i == 3) ra = 32'h0;
      if (!w) begin ra &= 32'hFF; rb &= 32'hFF; end
      do_check_op($sformatf("rnd%0d", i), w, s, ra, rb, ref_mul(w, s, ra, rb));
    end

    // Zero operand with a start pulse mid-CALC: ignored, exactly one done
    @(negedge clk);
    a32 = 32'h0; b32 = 32'h12345678; sm32 = 0; start32 = 1;
    @(negedge clk); start32 = 0;
    repeat (4) @(negedge clk);
    a32 = 32'h5; b32 = 32'h7; start32 = 1;
    @(negedge clk); start32 = 0;
    nd = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done32) nd++;
    end
    chk("ign_ndone", 64'(nd), 64'd1);
    chk("ign_z", z32, 64'd0);
    chk("ign_zero", 64'(zero32), 64'd1);

    // Back-to-back with start held high: one done every WIDTH+2 cycles
    a8 = 8'd13; b8 = 8'd11; sm8 = 0;
    expq.push_back(ref_mul(0, 0, 32'd13, 32'd11));
    @(negedge clk); start8 = 1;
    nd = 0; last = -1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (done8) begin
        chk($sformatf("b2b_z%0d", nd), 64'(z8), expq[nd]);
        if (last >= 0) chk($sformatf("b2b_per%0d", nd), 64'(c - last), 64'd10);
        last = c; nd++;
        if (nd == 4) break;
        a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom_range(0, 1));
        expq.push_back(ref_mul(0, sm8, {24'b0, a8}, {24'b0, b8}));
      end
    end
    start8 = 0;
    chk("b2b_count", 64'(nd), 64'd4);

    // Clear mid-CALC: back to IDLE, no done, z keeps prior result
    do_check_op("pre_clr", 1'b1, 1'b0, 32'd2, 32'd3, 64'd6);
    @(negedge clk);
    a32 = 32'd5; b32 = 32'd5; start32 = 1;
    @(negedge clk); start32 = 0;
    repeat (9) @(negedge clk);
    clear32 = 1;
    @(negedge clk); clear32 = 0;
    chk("clr_busy", 64'(busy32), 64'd0);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done32) nd++;
    end
    chk("clr_ndone", 64'(nd), 64'd0);
    chk("clr_z", z32, 64'd6);

    // Reset mid-CALC: outputs drop immediately, no done after release
    do_check_op("pre_rst", 1'b0, 1'b0, 32'd3, 32'd4, 64'd12);
    @(negedge clk);
    a8 = 8'd7; b8 = 8'd9; start8 = 1;
    @(negedge clk); start8 = 0;
    repeat (3) @(negedge clk);
    reset_n = 0;
    #1;
    chk("arst_z", 64'(z8), 64'd0);
    chk("arst_busy", 64'(busy8), 64'd0);
    chk("arst_zero", 64'(zero8), 64'd1);
    @(negedge clk); reset_n = 1;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done8) nd++;
    end
    chk("arst_ndone", 64'(nd), 64'd0);
    chk("arst_busy_after", 64'(busy8), 64'd0);

    // First start after reset is accepted
    do_check_op("post_rst", 1'b0, 1'b1, 32'h81, 32'h7F, ref_mul(0, 1, 32'h81, 32'h7F));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
